ifetch_unit: RTL

IFETCH_UNIT -- requirements
Module: ifetch_unit

---
 rtl/ifetch_pkg.sv | 41 ++++
 rtl/ifetch_unit_ifid_reg.sv | 50 +++++
 rtl/ifetch_unit.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/ifetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ifetch_pkg
// Purpose  : Shared types and constants for the instruction fetch unit and
//            the decode controller (FSM states, bubble word, RV32I opcodes).
// Revision : 1.0 - initial release
// ============================================================================
package ifetch_pkg;

   // Fetch FSM states; exactly one memory request may be in flight.
   typedef enum logic [1:0] {
      ST_ISSUE = 2'd0,
      ST_WAIT  = 2'd1,
      ST_HOLD  = 2'd2,
      ST_DRAIN = 2'd3
   } fetch_state_t;

   // Bubble instruction: ADDI x0,x0,0
   localparam logic [31:0] c_nop_instr = 32'h0000_0013;
   localparam logic [31:0] c_pc_inc    = 32'd4;

   // RV32I major opcodes (instr[6:0])
   localparam logic [6:0] c_opc_lui      = 7'b0110111;
   localparam logic [6:0] c_opc_auipc    = 7'b0010111;
   localparam logic [6:0] c_opc_jal      = 7'b1101111;
   localparam logic [6:0] c_opc_jalr     = 7'b1100111;
   localparam logic [6:0] c_opc_branch   = 7'b1100011;
   localparam logic [6:0] c_opc_load     = 7'b0000011;
   localparam logic [6:0] c_opc_store    = 7'b0100011;
   localparam logic [6:0] c_opc_op_imm   = 7'b0010011;
   localparam logic [6:0] c_opc_op       = 7'b0110011;
   localparam logic [6:0] c_opc_misc_mem = 7'b0001111;
   localparam logic [6:0] c_opc_system   = 7'b1110011;

   // Sequential next PC; wraps naturally modulo 2^32.
   function automatic logic [31:0] pc_next(input logic [31:0] pc);
      return pc + c_pc_inc;
   endfunction

endpackage
`default_nettype wire

// File: rtl/ifetch_unit_ifid_reg.sv
`default_nettype none
// ============================================================================
// Module   : ifid_reg
// Purpose  : IF/ID pipeline register. Priority flush > stall > write; with no
//            write the contents are simply held (valid never self-clears).
// Revision : 1.0 - initial release
// ============================================================================
module ifid_reg
   import ifetch_pkg::*;
#(
   parameter logic [31:0] NOP_INSTR = c_nop_instr
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        flush_i,
   input  logic        stall_i,
   input  logic        we_i,
   input  logic [31:0] pc_i,
   input  logic [31:0] instr_i,
   output logic        valid_o,
   output logic [31:0] pc_o,
   output logic [31:0] instr_o
);

   logic        valid_q;
   logic [31:0] pc_q;
   logic [31:0] instr_q;

   // Flush squashes to a bubble but keeps the PC; stall freezes everything.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_q <= 1'b0;
         pc_q    <= 32'd0;
         instr_q <= NOP_INSTR;
      end else if (flush_i) begin
         valid_q <= 1'b0;
         instr_q <= NOP_INSTR;
      end else if (!stall_i && we_i) begin
         valid_q <= 1'b1;
         pc_q    <= pc_i;
         instr_q <= instr_i;
      end
   end

   assign valid_o = valid_q;
   assign pc_o    = pc_q;
   assign instr_o = instr_q;

endmodule
`default_nettype wire

// File: rtl/ifetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : ifetch_unit
// Purpose  : Single-outstanding-request instruction fetch: PC, fetch FSM
//            (ISSUE/WAIT/HOLD/DRAIN), 1-entry hold buffer and IF/ID register.
// Options  : IFETCH_STALL_CNT_EN - builds a saturating stall-cycle counter;
//            when undefined stall_cnt is tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module ifetch_unit
   import ifetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        flush,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic        ifid_valid,
   output logic [31:0] ifid_pc,
   output logic [31:0] ifid_instr,
   output logic [6:0]  ifid_opcode,
   output logic [31:0] stall_cnt
);

   fetch_state_t state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic [31:0]  hold_q, hold_d;
   logic         live_q;      // low for the whole reset and the edge releasing it
   logic         ifid_we;
   logic [31:0]  ifid_wdata;
   logic [31:0]  redirect_pc_al;

   assign redirect_pc_al = {redirect_pc[31:2], 2'b00};

   // State, PC and hold buffer; live_q keeps imem_req low while reset is held.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_ISSUE;
         pc_q    <= RESET_PC;
         hold_q  <= 32'd0;
         live_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         hold_q  <= hold_d;
         live_q  <= 1'b1;
      end
   end

   // Next-state logic and IF/ID write selection.
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      hold_d     = hold_q;
      ifid_we    = 1'b0;
      ifid_wdata = hold_q;
      case (state_q)
         ST_ISSUE: begin
            // A request goes out this cycle; a redirect must drain its reply.
            if (live_q) begin
               if (redirect) begin
                  pc_d    = redirect_pc_al;
                  state_d = ST_DRAIN;
               end else begin
                  state_d = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            if (redirect) begin
               pc_d    = redirect_pc_al;
               state_d = imem_rvalid ? ST_ISSUE : ST_DRAIN;
            end else if (imem_rvalid && !stall) begin
               ifid_we    = 1'b1;
               ifid_wdata = imem_rdata;
               pc_d       = pc_next(pc_q);
               state_d    = ST_ISSUE;
            end else if (imem_rvalid) begin
               hold_d  = imem_rdata;
               state_d = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (redirect) begin
               pc_d    = redirect_pc_al;
               state_d = ST_ISSUE;
            end else if (!stall) begin
               ifid_we = 1'b1;
               pc_d    = pc_next(pc_q);
               state_d = ST_ISSUE;
            end
         end
         ST_DRAIN: begin
            // Redirects keep retargeting the PC; the stale reply still has to
            // be consumed before a new request may go out.
            if (redirect) begin
               pc_d = redirect_pc_al;
            end
            if (imem_rvalid) begin
               state_d = ST_ISSUE;
            end
         end
         default: state_d = ST_ISSUE;
      endcase
   end

   assign imem_req  = live_q && (state_q == ST_ISSUE);
   assign imem_addr = pc_q;

   ifid_reg #(
      .NOP_INSTR (NOP_INSTR)
   ) u_ifid_reg (
      .clk     (clk),
      .reset   (reset),
      .flush_i (flush),
      .stall_i (stall),
      .we_i    (ifid_we),
      .pc_i    (pc_q),
      .instr_i (ifid_wdata),
      .valid_o (ifid_valid),
      .pc_o    (ifid_pc),
      .instr_o (ifid_instr)
   );

   assign ifid_opcode = ifid_instr[6:0];

`ifdef IFETCH_STALL_CNT_EN
   logic [31:0] stall_cnt_q;

   // Count stalled cycles, saturating at all-ones.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cnt_q <= 32'd0;
      end else if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
         stall_cnt_q <= stall_cnt_q + 32'd1;
      end
   end

   assign stall_cnt = stall_cnt_q;
`else
   assign stall_cnt = 32'd0;
`endif

endmodule
`default_nettype wire
